// File: rtl/ntt_seq_ctrl_if.sv
// ntt_seq_ctrl_if: CPU-side load/unload and NTT-core handshake bundle for the sequencer.
interface ntt_seq_ctrl_if #(parameter int ADDR_W = 7);
  logic ntt_we;
  logic ntt_mode_i;
  logic ntt_ready;
  logic ntt_valid;
  logic ntt_we_real;
  logic [ADDR_W-1:0] load_addr;
  logic ntt_start;
  logic ntt_mode;
  logic ntt_dmem_write;
  logic [ADDR_W-1:0] dmem_addr;
  logic busy;
  logic done;
  logic timeout_err;
  modport master (
    output ntt_we, ntt_mode_i, ntt_ready, ntt_valid,
    input ntt_we_real, load_addr, ntt_start, ntt_mode, ntt_dmem_write, dmem_addr, busy, done, timeout_err
  );
  modport slave (
    input ntt_we, ntt_mode_i, ntt_ready, ntt_valid,
    output ntt_we_real, load_addr, ntt_start, ntt_mode, ntt_dmem_write, dmem_addr, busy, done, timeout_err
  );
endinterface

// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl: NTT job sequencer (load, start, wait for completion, unload).
// Optional WAIT-state timeout abort is enabled by defining NTT_TIMEOUT_EN.
module ntt_seq_ctrl #(
  parameter int N_COEF = 128,
  parameter int ADDR_W = 7,
  parameter int TMO_W = 16,
  parameter int TIMEOUT = 1000
) (
  input logic CLK,
  input logic RST,
  ntt_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD, DONE} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(N_COEF - 1);
  state_t state, state_nxt;
  logic [ADDR_W:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic [ADDR_W-1:0] dmem_addr;
  logic ntt_start;
  logic ntt_mode;
  logic ntt_dmem_write;
  logic done;
  logic tmo_hit;
  logic we_ok;
  logic rd_ok;
  assign we_ok = bus.ntt_we && (state == IDLE || state == LOAD);
  assign rd_ok = bus.ntt_valid && state == UNLOAD;
  assign bus.ntt_we_real = we_ok;
  assign bus.load_addr = cnt[ADDR_W-1:0];
  assign bus.ntt_start = ntt_start;
  assign bus.ntt_mode = ntt_mode;
  assign bus.ntt_dmem_write = ntt_dmem_write;
  assign bus.dmem_addr = dmem_addr;
  assign bus.done = done;
  assign bus.busy = state inside {LOAD, START, WAIT, UNLOAD, DONE};
  always_ff @(posedge CLK) state <= !RST ? IDLE : state_nxt;
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: state_nxt = bus.ntt_we ? LOAD : IDLE;
      LOAD: state_nxt = (bus.ntt_we && cnt == LAST) ? START : LOAD;
      START: state_nxt = WAIT;
      WAIT: state_nxt = bus.ntt_ready ? UNLOAD : tmo_hit ? IDLE : WAIT;
      UNLOAD: state_nxt = (bus.ntt_valid && cnt == LAST) ? DONE : UNLOAD;
      default: state_nxt = IDLE;
    endcase
  end
  // cnt only survives in the counting states; every other state clears it
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt <= '0;
      tmo <= '0;
      ntt_mode <= 1'b0;
      ntt_start <= 1'b0;
      ntt_dmem_write <= 1'b0;
      dmem_addr <= '0;
      done <= 1'b0;
    end else begin
      cnt <= (we_ok || rd_ok) ? cnt + 1'b1 : (state inside {IDLE, LOAD, UNLOAD}) ? cnt : '0;
      tmo <= (state == START) ? '0 : (state == WAIT && tmo != '1) ? tmo + 1'b1 : tmo;
      ntt_mode <= (we_ok && state == IDLE) ? bus.ntt_mode_i : ntt_mode;
      ntt_start <= we_ok && state == LOAD && cnt == LAST;
      ntt_dmem_write <= rd_ok;
      dmem_addr <= rd_ok ? cnt[ADDR_W-1:0] : dmem_addr;
      done <= state == DONE;
    end
  end
`ifdef NTT_TIMEOUT_EN
  logic timeout_err;
  assign tmo_hit = tmo == TMO_W'(TIMEOUT - 1);
  assign bus.timeout_err = timeout_err;
  always_ff @(posedge CLK) begin
    if (!RST) timeout_err <= 1'b0;
    else if (we_ok && state == IDLE) timeout_err <= 1'b0;
    else if (state == WAIT && !bus.ntt_ready && tmo_hit) timeout_err <= 1'b1;
  end
`else
  logic unused_timeout;
  assign tmo_hit = 1'b0;
  assign unused_timeout = ^TMO_W'(TIMEOUT);
  assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// tb_ntt_seq_ctrl: randomized scoreboard bench; drivers push expected events, a negedge monitor pops and compares.
module tb_ntt_seq_ctrl #(
  parameter int N_COEF = 128,
  parameter int ADDR_W = 7,
  parameter int TMO_W = 16,
  parameter int TIMEOUT = 50
);
  localparam int RST_AT = N_COEF > 60 ? 60 : N_COEF / 2;
  typedef struct {int at; int val;} exp_t;
  exp_t q_we[$];
  exp_t q_start[$];
  exp_t q_wr[$];
  exp_t q_done[$];
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  ntt_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus();
  ntt_seq_ctrl #(.N_COEF(N_COEF), .ADDR_W(ADDR_W), .TMO_W(TMO_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (mon_en) begin
      if (bus.ntt_we_real) begin
        if (q_we.size() == 0) chk("we_real_unexpected", 1, 0);
        else begin
          e = q_we.pop_front();
          chk("we_real_cycle", cyc, e.at);
          chk("load_addr", int'(bus.load_addr), e.val);
        end
      end
      if (bus.ntt_start) begin
        if (q_start.size() == 0) chk("start_unexpected", 1, 0);
        else begin
          e = q_start.pop_front();
          chk("start_cycle", cyc, e.at);
          chk("start_mode", int'(bus.ntt_mode), e.val);
        end
      end
      if (bus.ntt_dmem_write) begin
        if (q_wr.size() == 0) chk("dmem_write_unexpected", 1, 0);
        else begin
          e = q_wr.pop_front();
          chk("dmem_write_cycle", cyc, e.at);
          chk("dmem_addr", int'(bus.dmem_addr), e.val);
        end
      end
      if (bus.done) begin
        if (q_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = q_done.pop_front();
          chk("done_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_state(input string tag, input int busy_e, input int err_e);
    @(negedge CLK);
    chk({tag, "_busy"}, int'(bus.busy), busy_e);
    chk({tag, "_timeout_err"}, int'(bus.timeout_err), err_e);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset(input string tag);
    @(negedge CLK);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_start"}, int'(bus.ntt_start), 0);
    chk({tag, "_mode"}, int'(bus.ntt_mode), 0);
    chk({tag, "_dmem_write"}, int'(bus.ntt_dmem_write), 0);
    chk({tag, "_dmem_addr"}, int'(bus.dmem_addr), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_timeout_err"}, int'(bus.timeout_err), 0);
    chk({tag, "_load_addr"}, int'(bus.load_addr), 0);
    @(posedge CLK);
    #1;
  endtask

  // Entered in an IDLE cycle; returns in the START cycle.
  task automatic load_job(input bit mode, input int gap);
    for (int i = 0; i < N_COEF; i++) begin
      bus.ntt_we = 1'b1;
      bus.ntt_mode_i = (i == 0) ? mode : ~mode;
      q_we.push_back(exp_t'{cyc, i});
      if (i == N_COEF - 1) q_start.push_back(exp_t'{cyc + 1, int'(mode)});
      tick();
      bus.ntt_we = 1'b0;
      bus.ntt_mode_i = 1'b0;
      if (i < N_COEF - 1) repeat (gap < 0 ? int'($urandom_range(2)) : gap) tick();
    end
  endtask

  // Drives ready dly cycles later, with stray load beats on the first `extra` of them.
  task automatic wait_phase(input int dly, input int extra);
    for (int d = 1; d <= dly; d++) begin
      tick();
      bus.ntt_we = (d <= extra);
      bus.ntt_mode_i = 1'($urandom);
      bus.ntt_ready = (d == dly);
    end
    tick();
    bus.ntt_we = 1'b0;
    bus.ntt_ready = 1'b0;
  endtask

  task automatic unload(input bit bursty, input int stop);
    for (int j = 0; j < stop; j++) begin
      if (bursty && $urandom_range(9) < 3) repeat ($urandom_range(4, 1)) tick();
      bus.ntt_valid = 1'b1;
      q_wr.push_back(exp_t'{cyc + 1, j});
      if (j == N_COEF - 1) q_done.push_back(exp_t'{cyc + 2, 0});
      tick();
      bus.ntt_valid = 1'b0;
    end
  endtask

  // Full unload, then a load beat in the DONE cycle that must be dropped; returns in IDLE.
  task automatic finish(input bit bursty);
    unload(bursty, N_COEF);
    bus.ntt_we = 1'b1;
    bus.ntt_mode_i = 1'($urandom);
    tick();
    bus.ntt_we = 1'b0;
  endtask

  task automatic run_job(input bit mode, input int gap, input int dly, input int extra, input bit bursty);
    load_job(mode, gap);
    wait_phase(dly, extra);
    finish(bursty);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int d;
    bus.ntt_we = 1'b0;
    bus.ntt_mode_i = 1'b0;
    bus.ntt_ready = 1'b0;
    bus.ntt_valid = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    RST = 1'b1;
    mon_en = 1'b1;
    run_job(1'b0, 0, 40, 0, 1'b0);
    run_job(1'b1, 1, 12, 3, 1'b1);
    bus.ntt_valid = 1'b1;
    tick();
    bus.ntt_valid = 1'b0;
    tick();
`ifdef NTT_TIMEOUT_EN
    load_job(1'b0, 0);
    repeat (TIMEOUT) tick();
    check_state("tmo_last_wait", 1, 0);
    check_state("tmo_abort", 0, 1);
    fork
      load_job(1'b1, 0);
      begin
        @(negedge CLK);
        chk("tmo_err_first_beat", int'(bus.timeout_err), 1);
        @(negedge CLK);
        chk("tmo_err_cleared", int'(bus.timeout_err), 0);
      end
    join
    wait_phase(5, 0);
    finish(1'b0);
`else
    load_job(1'b0, 0);
    repeat (TIMEOUT + 10) tick();
    check_state("no_tmo_wait", 1, 0);
    wait_phase(1, 0);
    finish(1'b1);
`endif
    load_job(1'b1, -1);
    wait_phase(10, 0);
    unload(1'b0, RST_AT);
    bus.ntt_valid = 1'b1;
    RST = 1'b0;
    tick();
    bus.ntt_valid = 1'b0;
    check_reset("mid_rst");
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = $urandom_range(20, 1);
      run_job(1'($urandom), -1, d, d > 3 ? 3 : 0, 1'b1);
    end
    repeat (5) tick();
    chk("q_we_empty", q_we.size(), 0);
    chk("q_start_empty", q_start.size(), 0);
    chk("q_wr_empty", q_wr.size(), 0);
    chk("q_done_empty", q_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ntt_seq_ctrl.md
# ntt_seq_ctrl

Parametrised sequencer for the NTT accelerator. It collects `N_COEF` input coefficients into the core's BRAM and issues a one-cycle start with a latched NTT/INTT mode. It then waits for the core's completion pulse instead of a fixed cycle count, and streams `N_COEF` results back to data memory with generated addresses. It sits between the CPU-side data-memory port and the NTT core and replaces the fixed 128-coefficient control sequencer.

## Interface
Parameters:
- `N_COEF`, 128, coefficients per transform; must be ≥ 2.
- `ADDR_W`, 7, coefficient address width; requires 2^ADDR_W ≥ `N_COEF`.
- `TMO_W`, 16, width of the wait/timeout counter.
- `TIMEOUT`, 1000, maximum cycles in WAIT before abort (used only with `NTT_TIMEOUT_EN`); must be < 2^TMO_W.

Ports:
- `CLK`  in  1  clock; all logic on the rising edge.
- `RST`  in  1  reset; synchronous, active-low.
- `ntt_we`  in  1  input-coefficient write beat from the CPU side.
- `ntt_mode_i`  in  1  0 = forward NTT, 1 = inverse; sampled on the first accepted load beat.
- `ntt_ready`  in  1  core completion pulse.
- `ntt_valid`  in  1  core output-coefficient valid beat.
- `ntt_we_real`  out  1  gated write enable to the core BRAM (combinational).
- `load_addr`  out  ADDR_W  BRAM address for the current load beat (combinational from the load counter).
- `ntt_start`  out  1  one-cycle start to the core (registered).
- `ntt_mode`  out  1  mode latched for the current job.
- `ntt_dmem_write`  out  1  data-memory write strobe, `ntt_valid` delayed one cycle.
- `dmem_addr`  out  ADDR_W  data-memory address aligned with `ntt_dmem_write`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the final result is written.
- `timeout_err`  out  1  sticky abort flag.

## Operation
- States: IDLE, LOAD, START, WAIT, UNLOAD, DONE.
- `ntt_we_real` = `ntt_we` && state ∈ {IDLE, LOAD}. Beats in any other state are dropped and are never counted.
- `load_addr` = `cnt`, which is 0 in IDLE.
- IDLE:
  - On `ntt_we`: the beat is accepted at address 0, `cnt` becomes 1, `ntt_mode` latches `ntt_mode_i`, `timeout_err` clears, and the state moves to LOAD.
- LOAD:
  - Each `ntt_we` beat is written at `load_addr` = `cnt`, then `cnt` increments.
  - The beat accepted with `cnt` = `N_COEF`-1 moves the state to START.
  - Cycles without `ntt_we` hold state and `cnt`.
- START: `ntt_start` = 1 for exactly this cycle; `cnt` and `tmo` clear; next state is WAIT.
- WAIT:
  - `tmo` increments every cycle.
  - `ntt_ready` = 1 moves the state to UNLOAD with `cnt` = 0.
  - If `ntt_ready` and the timeout condition occur in the same cycle, `ntt_ready` wins.
- UNLOAD:
  - Each `ntt_valid` beat registers `ntt_dmem_write` = 1 and `dmem_addr` = `cnt` for the next cycle, then increments `cnt`.
  - The beat with `cnt` = `N_COEF`-1 moves the state to DONE.
  - `ntt_valid` outside UNLOAD is ignored.
- DONE: `done` = 1 for one cycle; next state is IDLE. A `ntt_we` beat arriving in DONE is dropped.
- Unreachable state encodings return to IDLE with no outputs asserted.
- Counters: `cnt` is ADDR_W+1 bits and wraps only via explicit clear. `tmo` is TMO_W bits and saturates rather than wrapping.

## Timing
- Reset: every register clears and state = IDLE. `ntt_start`, `ntt_mode`, `ntt_dmem_write`, `dmem_addr`, `done`, `timeout_err` and `busy` are all 0.
- Reset mid-job: the job aborts, no `done` pulse occurs, and nothing is written after the reset edge.
- Load to start: `ntt_start` is high exactly one cycle after the final accepted load beat.
- Unload latency: `ntt_dmem_write` and `dmem_addr` lag `ntt_valid` by exactly one cycle.
- Completion: `done` is high in the cycle after the last `ntt_dmem_write` pulse is issued, i.e. one cycle after that pulse.
- Back-to-back jobs: a new `ntt_we` is accepted no earlier than the cycle after DONE, when state = IDLE.

## Configuration
- `NTT_TIMEOUT_EN` defined:
  - In WAIT, when `tmo` = `TIMEOUT`-1 with no `ntt_ready`, `timeout_err` is set and the state moves to IDLE without `done`.
  - `timeout_err` holds until the next accepted load beat.
- `NTT_TIMEOUT_EN` undefined:
  - WAIT exits only on `ntt_ready`.
  - `timeout_err` is tied to 0 and the `tmo` comparison logic is absent.

## Test plan
- Nominal job, `N_COEF`=128:
  - Stimulus: 128 contiguous `ntt_we` beats, `ntt_ready` 40 cycles after start, then 128 `ntt_valid` beats.
  - Response: `load_addr` 0..127, one `ntt_start` pulse, `dmem_addr` 0..127 each one cycle after its `ntt_valid`, then one `done` pulse.
- Gapped load:
  - Stimulus: `ntt_we` on alternate cycles with `ntt_mode_i`=1 on the first beat only, plus 3 extra `ntt_we` beats during WAIT.
  - Response: `ntt_mode`=1, only 128 `ntt_we_real` pulses, extra beats dropped.
- Gapped unload:
  - Stimulus: `ntt_valid` in random bursts, plus a stray `ntt_valid` pulse in IDLE.
  - Response: exactly 128 `ntt_dmem_write` pulses, addresses strictly 0..127, stray pulse ignored.
- Timeout, with `NTT_TIMEOUT_EN` and `TIMEOUT`=50:
  - Stimulus: no `ntt_ready` after start.
  - Response: `timeout_err`=1 and `busy`=0 after 50 WAIT cycles, no `done`; the flag clears on the next load beat.
- Reset mid-UNLOAD:
  - Stimulus: RST=0 after 60 results have been written.
  - Response: all outputs 0 on the next edge, and a fresh job completes normally afterwards.
- Parameter sweep:
  - Stimulus: `N_COEF`=256 with `ADDR_W`=8, and `N_COEF`=2.
  - Response: address ranges 0..255 and 0..1 respectively, with correct `done` timing.
